// File: rtl/rf_pulse_gen_multi.sv
// Clocked RF burst generator: square wave while the envelope is high, half-period chosen per burst.
// Define RF_CYCLE_LIMIT_EN to end bursts after MAX_CYCLES completed RF cycles.
module rf_pulse_gen_multi #(
  parameter int CNT_W       = 8,
  parameter int FSEL_W      = 4,
  parameter int HALF_BASE_0 = 25,
  parameter int HALF_BASE_1 = 50,
  parameter int HALF_MAX    = 200,
  parameter int CYC_W       = 8,
  parameter int MAX_CYCLES  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              bb_pulse,
  input  logic              bit_val,
  input  logic [FSEL_W-1:0] freq_sel,
  output logic              rf_out,
  output logic              busy,
  output logic              pulse_done,
  output logic [CYC_W-1:0]  rf_cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TAIL = 2'd2
  } state_t;

  localparam logic [CNT_W:0]   BASE0_W  = HALF_BASE_0[CNT_W:0];
  localparam logic [CNT_W:0]   BASE1_W  = HALF_BASE_1[CNT_W:0];
  localparam logic [CNT_W:0]   HMAX_W   = HALF_MAX[CNT_W:0];
  localparam logic [CNT_W:0]   HONE_W   = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CYC_W-1:0] CYC_ZERO = {CYC_W{1'b0}};
  localparam logic [CYC_W-1:0] CYC_ONE  = {{(CYC_W-1){1'b0}}, 1'b1};
  localparam logic [CYC_W-1:0] CYC_SAT  = {CYC_W{1'b1}};
  localparam logic [CYC_W-1:0] CYC_LIM  = MAX_CYCLES[CYC_W-1:0];
`ifdef RF_CYCLE_LIMIT_EN
  localparam logic LIMIT_EN = 1'b1;
`else
  localparam logic LIMIT_EN = 1'b0;
`endif

  // Base plus offset at CNT_W+1 bits, clamped to [1, HALF_MAX].
  function automatic logic [CNT_W-1:0] calc_half(input logic b, input logic [FSEL_W-1:0] fs);
    logic [CNT_W:0] sum;
    sum = (b ? BASE1_W : BASE0_W) + {{(CNT_W+1-FSEL_W){1'b0}}, fs};
    if (sum > HMAX_W) begin
      sum = HMAX_W;
    end else if (sum == {(CNT_W+1){1'b0}}) begin
      sum = HONE_W;
    end else begin
      sum = sum;
    end
    return sum[CNT_W-1:0];
  endfunction

  state_t           state_r;
  logic             bb_q_r;
  logic             armed_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] half_r;
  logic             rise_s;
  logic             last_s;
  logic             stop_s;
  logic             limit_hit_s;

  // Edge detect, end-of-half-period and burst-stop conditions.
  always_comb begin
    rise_s      = bb_pulse & ~bb_q_r & armed_r;
    last_s      = (cnt_r == (half_r - CNT_ONE));
    stop_s      = ~bb_pulse | ~en;
    limit_hit_s = LIMIT_EN & last_s & ~rf_out & (rf_cycles >= CYC_LIM);
  end

  // Burst FSM with registered outputs. armed_r demands the envelope be seen low
  // after reset, so an envelope already high at reset release cannot start a burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      bb_q_r     <= 1'b0;
      armed_r    <= 1'b0;
      cnt_r      <= CNT_ZERO;
      half_r     <= CNT_ZERO;
      rf_out     <= 1'b0;
      busy       <= 1'b0;
      pulse_done <= 1'b0;
      rf_cycles  <= CYC_ZERO;
    end else begin
      bb_q_r     <= bb_pulse;
      armed_r    <= armed_r | ~bb_pulse;
      pulse_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (rise_s && en) begin
            half_r    <= calc_half(bit_val, freq_sel);
            cnt_r     <= CNT_ZERO;
            rf_cycles <= CYC_ZERO;
            rf_out    <= 1'b1;
            busy      <= 1'b1;
            state_r   <= RUN;
          end else begin
            rf_out <= 1'b0;
          end
        end
        RUN: begin
          cnt_r <= last_s ? CNT_ZERO : (cnt_r + CNT_ONE);
          if (limit_hit_s) begin
            busy       <= 1'b0;
            pulse_done <= 1'b1;
            state_r    <= IDLE;
          end else begin
            // A cycle is credited when its high phase completes.
            if (last_s) begin
              rf_out <= ~rf_out;
              if (rf_out && (rf_cycles != CYC_SAT)) begin
                rf_cycles <= rf_cycles + CYC_ONE;
              end
            end
            if (stop_s) begin
              state_r <= TAIL;
            end
          end
        end
        TAIL: begin
          if (last_s) begin
            cnt_r      <= CNT_ZERO;
            rf_out     <= 1'b0;
            busy       <= 1'b0;
            pulse_done <= 1'b1;
            state_r    <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          rf_out  <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_pulse_gen_multi.sv
// Scoreboard bench for rf_pulse_gen_multi: expected burst summaries are queued by the
// stimulus and checked by a monitor on each pulse_done strobe.
module tb_rf_pulse_gen_multi;

  logic       clk = 1'b0;
  logic       rst, en, bb_pulse, bit_val;
  logic [3:0] freq_sel;
  logic       rf_out, busy, pulse_done;
  logic [7:0] rf_cycles;

  typedef struct {
    int cyc;
    int nhigh;
    int half;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   done_cnt = 0;

  // monitor state
  logic prev_busy = 1'b0;
  logic prev_pd = 1'b0;
  logic cur_val = 1'b0;
  int   cur_len = 0;
  int   nhigh = 0;
  int   min_len = 0;
  int   max_len = 0;

  always #5 clk = ~clk;

  rf_pulse_gen_multi #(
    .CNT_W(8), .FSEL_W(4), .HALF_BASE_0(4), .HALF_BASE_1(6),
    .HALF_MAX(10), .CYC_W(8), .MAX_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .bb_pulse(bb_pulse), .bit_val(bit_val),
    .freq_sel(freq_sel), .rf_out(rf_out), .busy(busy), .pulse_done(pulse_done),
    .rf_cycles(rf_cycles)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input int nh, input int h);
    exp_t e;
    e.cyc = c; e.nhigh = nh; e.half = h;
    exp_q.push_back(e);
    pushed++;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt < pushed && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("done_timeout", (done_cnt >= pushed) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic run_burst(input logic b, input logic [3:0] fs, input int hi,
                           input int c, input int nh, input int h);
    bit_val = b; freq_sel = fs;
    push(c, nh, h);
    bb_pulse = 1'b1;
    cycles(hi);
    bb_pulse = 1'b0;
    wait_done();
    cycles(3);
  endtask

  task automatic close_phase();
    if (cur_len < min_len) min_len = cur_len;
    if (cur_len > max_len) max_len = cur_len;
  endtask

  // Monitor: measure phase lengths while busy and score each completed burst.
  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
      prev_pd   = 1'b0;
      cur_len   = 0;
    end else begin
      if (busy) begin
        if (!prev_busy) begin
          cur_val = rf_out; cur_len = 1; nhigh = rf_out ? 1 : 0;
          min_len = 1000; max_len = 0;
        end else if (rf_out == cur_val) begin
          cur_len++;
        end else begin
          close_phase();
          cur_val = rf_out; cur_len = 1;
          if (rf_out) nhigh++;
        end
      end else if (prev_busy) begin
        close_phase();
      end
      prev_busy = busy;
      if (pulse_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rf_cycles", {24'd0, rf_cycles}, e.cyc);
          chk("high_phases", nhigh, e.nhigh);
          chk("min_phase", min_len, e.half);
          chk("max_phase", max_len, e.half);
          chk("done_idle_low", {30'd0, busy, rf_out}, 32'd0);
          chk("done_single", {31'd0, prev_pd}, 32'd0);
        end
        done_cnt++;
      end
      prev_pd = pulse_done;
    end
  end

  initial begin
    int seen;
    rst = 1'b1; en = 1'b1; bb_pulse = 1'b0; bit_val = 1'b0; freq_sel = 4'd0;
    cycles(3);
    chk("rst_rf_out", {31'd0, rf_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pulse_done", {31'd0, pulse_done}, 32'd0);
    chk("rst_rf_cycles", {24'd0, rf_cycles}, 32'd0);
    rst = 1'b0;
    cycles(2);

    // bit 1, half 6+2=8, envelope 40 cycles
`ifdef RF_CYCLE_LIMIT_EN
    run_burst(1'b1, 4'd2, 40, 2, 2, 8);
`else
    run_burst(1'b1, 4'd2, 40, 3, 3, 8);
`endif
    // bit 0, 4+15 clamps to 10; last toggle coincides with envelope drop
    run_burst(1'b0, 4'd15, 30, 2, 2, 10);
    // envelope drops at cnt=2 of the first high phase
    run_burst(1'b1, 4'd2, 3, 0, 1, 8);

    // bit/offset changes after start are ignored
    bit_val = 1'b1; freq_sel = 4'd2;
    push(1, 2, 8);
    bb_pulse = 1'b1;
    cycles(1);
    bit_val = 1'b0; freq_sel = 4'd15;
    cycles(19);
    bb_pulse = 1'b0;
    wait_done();
    cycles(3);

    // rise with en low does nothing; en drop mid-burst ends it
    en = 1'b0; bb_pulse = 1'b1;
    cycles(6);
    chk("en_gate_busy", {31'd0, busy}, 32'd0);
    bb_pulse = 1'b0;
    cycles(2);
    en = 1'b1; bit_val = 1'b1; freq_sel = 4'd2;
    push(0, 1, 8);
    bb_pulse = 1'b1;
    cycles(5);
    en = 1'b0;
    wait_done();
    bb_pulse = 1'b0; en = 1'b1;
    cycles(3);

    // one-cycle envelope gap: rise during TAIL must not restart
    push(1, 1, 8);
    bb_pulse = 1'b1;
    cycles(12);
    bb_pulse = 1'b0;
    cycles(1);
    bb_pulse = 1'b1;
    wait_done();
    seen = 0;
    repeat (20) begin cycles(1); seen |= busy; end
    chk("tail_rise_no_restart", seen, 0);
    bb_pulse = 1'b0;
    cycles(3);

    // reset mid-burst
    bb_pulse = 1'b1;
    cycles(12);
    chk("pre_rst_cycles", {24'd0, rf_cycles}, 32'd1);
    rst = 1'b1;
    cycles(1);
    chk("midrst_rf_out", {31'd0, rf_out}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_pulse_done", {31'd0, pulse_done}, 32'd0);
    chk("midrst_rf_cycles", {24'd0, rf_cycles}, 32'd0);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin cycles(1); seen |= busy; end
    chk("post_rst_no_start", seen, 0);
    bb_pulse = 1'b0;
    cycles(2);
    run_burst(1'b1, 4'd2, 3, 0, 1, 8);

`ifdef RF_CYCLE_LIMIT_EN
    // half 4, limit 2 cycles, envelope held 50 cycles
    bit_val = 1'b0; freq_sel = 4'd0;
    push(2, 2, 4);
    bb_pulse = 1'b1;
    cycles(20);
    chk("limit_no_restart", {31'd0, busy}, 32'd0);
    cycles(30);
    bb_pulse = 1'b0;
    wait_done();
    cycles(3);
`endif

    cycles(5);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
